flash_arbiter: RTL and testbench
================================

Name: flash_arbiter

Overview:
- Two-port request arbiter and command sequencer in front of the Pmod SF3 SPI flash master.
- Requester 0 is the game-state loader and requester 1 the score/save writer. Each issues single-byte read or write requests.
- The block grants requests round-robin and expands each one into the flash command sequence: READ (0x03), or WREN (0x06) followed by PP (0x02).
- It holds command, address and data stable for the whole transaction, returns read data and status per requester, and resets the master through a watchdog if it stalls.

Parameters:
- TIMEOUT_CYCLES, 1048576, max cycles from sf_start to sf_done before abort.
- TO_W, 21, width of the watchdog counter; must hold TIMEOUT_CYCLES.
- RST_CYCLES, 4, length of the sf_rst pulse on abort.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- req0_valid  in  1  requester 0 request; held until req0_ready
- req0_we  in  1  1=write byte, 0=read byte
- req0_addr  in  24  flash byte address
- req0_wdata  in  8  write data
- req0_ready  out  1  one-cycle accept pulse
- rsp0_valid  out  1  one-cycle completion pulse
- rsp0_err  out  1  valid with rsp0_valid; 1=timeout abort
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_err  as for port 0
- rsp_rdata  out  8  read data, valid with either rsp*_valid; 0x00 for writes and errors
- sf_start  out  1  one-cycle start pulse to the master
- sf_cmd  out  8  command byte
- sf_addr  out  24  address, registered
- sf_data_in  out  8  write byte, registered
- sf_data_len  out  8  constant 8'd1
- sf_data_out  in  8  master read data
- sf_done  in  1  master completion pulse
- sf_rst  out  1  master reset; the top level ORs it with the system reset
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set on any abort, cleared only by reset

Behaviour:
- Reset values: all outputs 0 except sf_data_len=1. FSM in IDLE. Round-robin pointer last=1, so port 0 wins the first tie.
- States: IDLE, GRANT, WREN_GO, WREN_WAIT, OP_GO, OP_WAIT, RESP, ABORT.
- IDLE:
  - Any valid -> GRANT.
  - Both valid -> grant the port != last.
- GRANT (1 cycle):
  - Pulse reqN_ready.
  - Latch id, we, addr, wdata into internal registers; sf_addr and sf_data_in drive from these until RESP.
  - Set last=id.
  - we=1 -> WREN_GO; we=0 -> OP_GO.
- WREN_GO: sf_cmd=0x06, sf_start=1 for 1 cycle -> WREN_WAIT.
- WREN_WAIT:
  - sf_done -> OP_GO. The master is back in IDLE on the cycle after done, so a start is legal on the next cycle.
- OP_GO: sf_cmd = we ? 0x02 : 0x03, sf_start=1 for 1 cycle -> OP_WAIT.
- OP_WAIT:
  - sf_done -> RESP.
  - Capture sf_data_out on that cycle for reads; force 0x00 for writes.
  - Write completion includes the master's internal status poll; no polling happens here.
- RESP (1 cycle):
  - Pulse rspN_valid with rsp_rdata and rspN_err.
  - Return to IDLE. Earliest next grant is the cycle after.
- sf_cmd holds its value from *_GO until the next *_GO.
- Watchdog:
  - Counter clears on every sf_start and increments in WREN_WAIT and OP_WAIT.
  - Reaching TIMEOUT_CYCLES-1 -> ABORT.
- ABORT:
  - sf_rst=1 for RST_CYCLES; set timeout_err.
  - Then RESP with err=1, rdata=0x00.
  - A WREN timeout skips PP.
- Latency with an ideal master: read = 1 (GRANT) + 1 (GO) + T_master + 1 (RESP).
- Boundary conditions:
  - Requests arriving while busy are not granted. reqN_valid must stay asserted; the port waits with no loss.
  - A request deasserted before ready is dropped silently; this is a protocol violation, not checked.
  - sf_done arriving outside a WAIT state is ignored.
  - Reset mid-transaction returns the FSM to IDLE immediately with no response. Outstanding requesters must reissue.
  - Addresses pass through unmodified. Wrap-around is the master's and flash's concern.

Decomposition:
- Shared package flash_pkg holds CMD_READ=0x03, CMD_WREN=0x06, CMD_PP=0x02, CMD_RDSR=0x05 and the FSM state encodings. The SPI master is expected to take these same command constants.
- One sub-module: rr_arb2 (2-way round-robin, combinational grant plus registered last pointer).
- The watchdog stays inline.

Test Plan:
- Read: req0 read addr 0x000123, master model returns 0xA5 -> sf_cmd 0x03 with one sf_start, then rsp0_valid with rsp_rdata=0xA5 and err=0.
- Write: req1 write addr 0x01FF00, wdata 0x3C -> two sf_start pulses, cmds 0x06 then 0x02. sf_addr=0x01FF00 and sf_data_in=0x3C stay stable throughout. Then rsp1_valid, rdata=0x00.
- Tie: both ports valid in the same cycle from reset, repeated 4 times -> grants alternate 0,1,0,1. No ready pulse occurs while busy.
- Timeout: TIMEOUT_CYCLES=64, model never asserts done -> ABORT. sf_rst high for 4 cycles, rsp0_err=1, timeout_err sticky. The next request completes normally.
- Reset mid-op: assert reset during OP_WAIT -> all outputs at reset values on the same edge, no rsp pulse. A post-reset request succeeds.
- Back-to-back: req0 held valid through 3 reads -> exactly 3 ready and 3 rsp pulses. Each sf_start comes at least 1 cycle after the previous sf_done.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared constants and types for the flash request arbiter and the SPI flash master.
// The master decodes the same command bytes, so they live here rather than in either block.
package flash_pkg;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WREN_GO,
        S_WREN_WAIT,
        S_OP_GO,
        S_OP_WAIT,
        S_RESP,
        S_ABORT
    } state_e;

    // One accepted request, held for the whole flash transaction.
    typedef struct packed {
        logic        id;
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
    } txn_t;
endpackage

// File: rtl/flash_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-granted pointer.
// On a tie, the port that was not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic       any_o,
    output logic       gnt_id_o
);
    logic last_q;

    always_comb begin
        any_o    = |req_i;
        gnt_id_o = (&req_i) ? ~last_q : req_i[1];
    end

    // Reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_q <= 1'b1;
        else if (upd_i && any_o)
            last_q <= gnt_id_o;
    end
endmodule

// File: rtl/flash_arbiter.sv
// Two-port request arbiter and command sequencer for the Pmod SF3 SPI flash master.
// Each request becomes READ, or WREN then PP, with a watchdog that resets a stalled master.
module flash_arbiter
    import flash_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TO_W           = 21,
    parameter int RST_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [23:0] req0_addr,
    input  logic [7:0]  req0_wdata,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic        rsp0_err,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [23:0] req1_addr,
    input  logic [7:0]  req1_wdata,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic        rsp1_err,
    output logic [7:0]  rsp_rdata,
    output logic        sf_start,
    output logic [7:0]  sf_cmd,
    output logic [23:0] sf_addr,
    output logic [7:0]  sf_data_in,
    output logic [7:0]  sf_data_len,
    input  logic [7:0]  sf_data_out,
    input  logic        sf_done,
    output logic        sf_rst,
    output logic        busy,
    output logic        timeout_err
);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] RST_LAST = TO_W'(RST_CYCLES - 1);

    state_e          state_q;
    txn_t            txn_q, req_txn;
    logic [TO_W-1:0] wd_q;
    logic [1:0]      ready_q, rsp_q;
    logic            err_q, start_q, srst_q, toerr_q;
    logic [7:0]      rdata_q, cmd_q;
    logic            any_req, gnt_id;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({req1_valid, req0_valid}),
        .upd_i    (state_q == S_IDLE),
        .any_o    (any_req),
        .gnt_id_o (gnt_id)
    );

    always_comb begin
        req_txn.id    = gnt_id;
        req_txn.we    = gnt_id ? req1_we    : req0_we;
        req_txn.addr  = gnt_id ? req1_addr  : req0_addr;
        req_txn.wdata = gnt_id ? req1_wdata : req0_wdata;
    end

    // wd_q doubles as the stall watchdog in *_WAIT and the reset-pulse timer in ABORT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            txn_q   <= '0;
            wd_q    <= '0;
            ready_q <= '0;
            rsp_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            start_q <= 1'b0;
            cmd_q   <= '0;
            srst_q  <= 1'b0;
            toerr_q <= 1'b0;
        end else begin
            ready_q <= '0;
            rsp_q   <= '0;
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: if (any_req) begin
                    state_q         <= S_GRANT;
                    ready_q[gnt_id] <= 1'b1;
                    txn_q           <= req_txn;
                end
                S_GRANT: begin
                    start_q <= 1'b1;
                    wd_q    <= '0;
                    cmd_q   <= txn_q.we ? CMD_WREN : CMD_READ;
                    state_q <= txn_q.we ? S_WREN_GO : S_OP_GO;
                end
                S_WREN_GO: state_q <= S_WREN_WAIT;
                S_OP_GO:   state_q <= S_OP_WAIT;
                S_WREN_WAIT: begin
                    if (sf_done) begin
                        state_q <= S_OP_GO;
                        start_q <= 1'b1;
                        cmd_q   <= CMD_PP;
                        wd_q    <= '0;
                    end else if (wd_q == TO_LAST) begin
                        state_q <= S_ABORT;
                        srst_q  <= 1'b1;
                        toerr_q <= 1'b1;
                        wd_q    <= '0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_OP_WAIT: begin
                    if (sf_done) begin
                        state_q          <= S_RESP;
                        rsp_q[txn_q.id]  <= 1'b1;
                        err_q            <= 1'b0;
                        rdata_q          <= txn_q.we ? 8'h00 : sf_data_out;
                    end else if (wd_q == TO_LAST) begin
                        state_q <= S_ABORT;
                        srst_q  <= 1'b1;
                        toerr_q <= 1'b1;
                        wd_q    <= '0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_ABORT: begin
                    if (wd_q == RST_LAST) begin
                        state_q         <= S_RESP;
                        srst_q          <= 1'b0;
                        rsp_q[txn_q.id] <= 1'b1;
                        err_q           <= 1'b1;
                        rdata_q         <= 8'h00;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    err_q   <= 1'b0;
                    rdata_q <= 8'h00;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req0_ready  = ready_q[0];
    assign req1_ready  = ready_q[1];
    assign rsp0_valid  = rsp_q[0];
    assign rsp1_valid  = rsp_q[1];
    assign rsp0_err    = rsp_q[0] & err_q;
    assign rsp1_err    = rsp_q[1] & err_q;
    assign rsp_rdata   = rdata_q;
    assign sf_start    = start_q;
    assign sf_cmd      = cmd_q;
    assign sf_addr     = txn_q.addr;
    assign sf_data_in  = txn_q.wdata;
    assign sf_data_len = 8'd1;
    assign sf_rst      = srst_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = toerr_q;
endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: a small SPI-master model answers sf_start after a
// programmable latency; per-scenario tasks drive requests and check recorded activity.
module tb_flash_arbiter;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
    logic [23:0] req0_addr = '0, req1_addr = '0;
    logic [7:0]  req0_wdata = '0, req1_wdata = '0;
    logic        req0_ready, rsp0_valid, rsp0_err, req1_ready, rsp1_valid, rsp1_err;
    logic [7:0]  rsp_rdata, sf_cmd, sf_data_in, sf_data_len, sf_data_out;
    logic [23:0] sf_addr;
    logic        sf_start, sf_rst, busy, timeout_err, sf_done;
    logic        mdl_done, inj_done = 1'b0;

    always #5 clk = ~clk;
    assign sf_done = mdl_done | inj_done;

    flash_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(21), .RST_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
        .rsp_rdata(rsp_rdata), .sf_start(sf_start), .sf_cmd(sf_cmd), .sf_addr(sf_addr),
        .sf_data_in(sf_data_in), .sf_data_len(sf_data_len), .sf_data_out(sf_data_out),
        .sf_done(sf_done), .sf_rst(sf_rst), .busy(busy), .timeout_err(timeout_err)
    );

    // Master model: done appears mdl_lat+1 cycles after the start cycle, unless hung.
    int         mdl_lat = 3;
    logic       mdl_hang = 1'b0;
    logic [7:0] mdl_rdata = 8'hA5;
    int         mdl_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdl_cnt  <= 0;
            mdl_done <= 1'b0;
        end else begin
            mdl_done <= 1'b0;
            if (sf_start) mdl_cnt <= mdl_lat;
            else if (mdl_cnt == 1) begin
                mdl_cnt     <= 0;
                mdl_done    <= !mdl_hang;
                sf_data_out <= mdl_rdata;
            end else if (mdl_cnt > 1) mdl_cnt <= mdl_cnt - 1;
        end
    end

    int vecs = 0, errs = 0;

    // Activity recorder, sampled on the falling edge.
    int          cyc = 0, n_start, n_rst, n_rd, n_gnt, rst_first, rdy_cyc, rsp_cyc;
    int          n_rdy [2];
    int          n_rsp [2];
    int          start_cyc [16];
    logic [7:0]  cmd_log [16];
    logic [7:0]  rd_log [16];
    logic        err_log [16];
    logic        gnt_log [16];
    int          bad_order, rdy_while_out, unstable;
    logic        outst, mst_busy, chk_wd;
    logic [23:0] exp_addr;
    logic [7:0]  exp_wd;
    int          want0, want1;

    task automatic mon_clear();
        n_start = 0; n_rst = 0; n_rd = 0; n_gnt = 0; rst_first = -1; rdy_cyc = -1; rsp_cyc = -1;
        n_rdy[0] = 0; n_rdy[1] = 0; n_rsp[0] = 0; n_rsp[1] = 0;
        bad_order = 0; rdy_while_out = 0; unstable = 0;
        outst = 1'b0; mst_busy = 1'b0; chk_wd = 1'b0;
        want0 = 1; want1 = 1;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (sf_start) begin
            if (mst_busy || sf_done) bad_order++;
            if (n_start < 16) begin cmd_log[n_start] = sf_cmd; start_cyc[n_start] = cyc; end
            n_start++;
            mst_busy = 1'b1;
        end else if (sf_done || sf_rst) mst_busy = 1'b0;
        if (req0_ready || req1_ready) begin
            if (outst) rdy_while_out++;
            outst = 1'b1;
            if (n_gnt < 16) gnt_log[n_gnt] = req1_ready;
            n_gnt++;
            rdy_cyc = cyc;
        end
        n_rdy[0] += int'(req0_ready);
        n_rdy[1] += int'(req1_ready);
        if (outst && (sf_addr !== exp_addr || (chk_wd && sf_data_in !== exp_wd))) unstable++;
        if (rsp0_valid || rsp1_valid) begin
            outst = 1'b0;
            if (n_rd < 16) begin rd_log[n_rd] = rsp_rdata; err_log[n_rd] = rsp0_err | rsp1_err; end
            n_rd++;
            rsp_cyc = cyc;
        end
        n_rsp[0] += int'(rsp0_valid);
        n_rsp[1] += int'(rsp1_valid);
        if (sf_rst) begin
            if (n_rst == 0) rst_first = cyc;
            n_rst++;
        end
    endtask

    // Steps until want_rsp responses are seen; each port drops valid after its quota of grants.
    task automatic run(input int want_rsp, input int max_cyc);
        int k = 0;
        while (n_rd < want_rsp && k < max_cyc) begin
            step();
            k++;
            if (req0_ready && n_rdy[0] >= want0) req0_valid = 1'b0;
            if (req1_ready && n_rdy[1] >= want1) req1_valid = 1'b0;
        end
        vecs++;
        if (n_rd < want_rsp) begin
            errs++;
            $display("FAIL run_bound: %0d of %0d responses after %0d cycles", n_rd, want_rsp, k);
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vecs++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, sf_start, sf_rst, busy, timeout_err} !== 10'b0) begin
            errs++; $display("FAIL reset_ctrl: got %b want 0", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, sf_start, sf_rst, busy, timeout_err}); end
        vecs++; if ({sf_cmd, sf_addr, sf_data_in, rsp_rdata} !== 48'h0) begin
            errs++; $display("FAIL reset_data: got %h want 0", {sf_cmd, sf_addr, sf_data_in, rsp_rdata}); end
        vecs++; if (sf_data_len !== 8'd1) begin errs++; $display("FAIL reset_len: got %0d want 1", sf_data_len); end
        reset = 1'b0;
    endtask

    task automatic test_read();
        mon_clear();
        mdl_lat = 3; mdl_rdata = 8'hA5; exp_addr = 24'h000123;
        req0_we = 1'b0; req0_addr = 24'h000123; req0_valid = 1'b1;
        run(1, 100);
        vecs++; if (n_start !== 1) begin errs++; $display("FAIL read_starts: got %0d want 1", n_start); end
        vecs++; if (cmd_log[0] !== 8'h03) begin errs++; $display("FAIL read_cmd: got %h want 03", cmd_log[0]); end
        vecs++; if (n_rsp[0] !== 1 || n_rsp[1] !== 0) begin errs++; $display("FAIL read_rsp: got %0d/%0d want 1/0", n_rsp[0], n_rsp[1]); end
        vecs++; if (rd_log[0] !== 8'hA5) begin errs++; $display("FAIL read_data: got %h want a5", rd_log[0]); end
        vecs++; if (err_log[0] !== 1'b0) begin errs++; $display("FAIL read_err: got %b want 0", err_log[0]); end
        vecs++; if (rsp_cyc - rdy_cyc !== 6) begin errs++; $display("FAIL read_latency: got %0d want 6", rsp_cyc - rdy_cyc); end
        vecs++; if (unstable !== 0) begin errs++; $display("FAIL read_addr_stable: got %0d bad cycles want 0", unstable); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL read_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_write();
        mon_clear();
        mdl_lat = 2; mdl_rdata = 8'h77; exp_addr = 24'h01FF00; exp_wd = 8'h3C; chk_wd = 1'b1;
        req1_we = 1'b1; req1_addr = 24'h01FF00; req1_wdata = 8'h3C; req1_valid = 1'b1;
        run(1, 100);
        vecs++; if (n_start !== 2) begin errs++; $display("FAIL write_starts: got %0d want 2", n_start); end
        vecs++; if ({cmd_log[0], cmd_log[1]} !== 16'h0602) begin errs++; $display("FAIL write_cmds: got %h want 0602", {cmd_log[0], cmd_log[1]}); end
        vecs++; if (start_cyc[1] - start_cyc[0] !== 4) begin errs++; $display("FAIL write_pp_gap: got %0d want 4", start_cyc[1] - start_cyc[0]); end
        vecs++; if (unstable !== 0) begin errs++; $display("FAIL write_stable: got %0d bad cycles want 0", unstable); end
        vecs++; if (bad_order !== 0) begin errs++; $display("FAIL write_order: got %0d want 0", bad_order); end
        vecs++; if (n_rsp[1] !== 1 || n_rsp[0] !== 0) begin errs++; $display("FAIL write_rsp: got %0d/%0d want 0/1", n_rsp[0], n_rsp[1]); end
        vecs++; if (rd_log[0] !== 8'h00 || err_log[0] !== 1'b0) begin errs++; $display("FAIL write_rdata: got %h err %b want 00 err 0", rd_log[0], err_log[0]); end
    endtask

    task automatic test_tie();
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        mon_clear();
        mdl_lat = 1; mdl_rdata = 8'h11; exp_addr = 24'h000040;
        want0 = 2; want1 = 2;
        req0_we = 1'b0; req1_we = 1'b0; req0_addr = 24'h000040; req1_addr = 24'h000040;
        req0_valid = 1'b1; req1_valid = 1'b1;
        run(4, 200);
        vecs++; if (n_gnt !== 4) begin errs++; $display("FAIL tie_grants: got %0d want 4", n_gnt); end
        vecs++; if ({gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]} !== 4'b0101) begin
            errs++; $display("FAIL tie_order: got %b want 0101", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}); end
        vecs++; if (rdy_while_out !== 0) begin errs++; $display("FAIL tie_ready_busy: got %0d want 0", rdy_while_out); end
        vecs++; if (n_rsp[0] !== 2 || n_rsp[1] !== 2) begin errs++; $display("FAIL tie_rsp: got %0d/%0d want 2/2", n_rsp[0], n_rsp[1]); end
    endtask

    task automatic test_stray_done();
        mon_clear();
        inj_done = 1'b1; step(); inj_done = 1'b0;
        repeat (4) step();
        vecs++; if (busy !== 1'b0 || n_rd !== 0 || n_start !== 0) begin
            errs++; $display("FAIL stray_done: busy %b rsp %0d start %0d want 0 0 0", busy, n_rd, n_start); end
    endtask

    task automatic test_timeout();
        mon_clear();
        mdl_hang = 1'b1; exp_addr = 24'h000200;
        req0_we = 1'b0; req0_addr = 24'h000200; req0_valid = 1'b1;
        run(1, 300);
        vecs++; if (n_rst !== 4) begin errs++; $display("FAIL to_rst_len: got %0d want 4", n_rst); end
        vecs++; if (rst_first - start_cyc[0] !== TO + 1) begin errs++; $display("FAIL to_when: got %0d want %0d", rst_first - start_cyc[0], TO + 1); end
        vecs++; if (n_rsp[0] !== 1 || err_log[0] !== 1'b1 || rd_log[0] !== 8'h00) begin
            errs++; $display("FAIL to_rsp: got n %0d err %b rd %h want 1 1 00", n_rsp[0], err_log[0], rd_log[0]); end
        vecs++; if (timeout_err !== 1'b1) begin errs++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
        // A stalled WREN must not be followed by PP.
        mon_clear();
        exp_addr = 24'h000300;
        req1_we = 1'b1; req1_addr = 24'h000300; req1_wdata = 8'h42; req1_valid = 1'b1;
        run(1, 300);
        vecs++; if (n_start !== 1 || cmd_log[0] !== 8'h06) begin errs++; $display("FAIL to_wren_skip: got %0d starts cmd %h want 1 06", n_start, cmd_log[0]); end
        vecs++; if (n_rsp[1] !== 1 || err_log[0] !== 1'b1 || n_rst !== 4) begin
            errs++; $display("FAIL to_wren_rsp: got n %0d err %b rst %0d want 1 1 4", n_rsp[1], err_log[0], n_rst); end
        mon_clear();
        mdl_hang = 1'b0; mdl_lat = 2; mdl_rdata = 8'h5A; exp_addr = 24'h000201;
        req0_we = 1'b0; req0_addr = 24'h000201; req0_valid = 1'b1;
        run(1, 100);
        vecs++; if (rd_log[0] !== 8'h5A || err_log[0] !== 1'b0) begin errs++; $display("FAIL to_recover: got %h err %b want 5a 0", rd_log[0], err_log[0]); end
        vecs++; if (timeout_err !== 1'b1) begin errs++; $display("FAIL to_still_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_midop();
        int k = 0;
        mon_clear();
        mdl_lat = 20; exp_addr = 24'h000400;
        req0_we = 1'b0; req0_addr = 24'h000400; req0_valid = 1'b1;
        while (n_start == 0 && k < 20) begin
            step(); k++;
            if (req0_ready) req0_valid = 1'b0;
        end
        repeat (3) step();
        reset = 1'b1; req0_valid = 1'b0;
        #1;
        vecs++; if ({busy, sf_start, sf_rst, timeout_err, rsp0_valid, rsp1_valid} !== 6'b0 || {sf_cmd, sf_addr} !== 32'h0) begin
            errs++; $display("FAIL rst_mid_outputs: got ctl %b cmd %h addr %h want 0", {busy, sf_start, sf_rst, timeout_err, rsp0_valid, rsp1_valid}, sf_cmd, sf_addr); end
        @(negedge clk); reset = 1'b0;
        mon_clear();
        repeat (25) step();
        vecs++; if (n_rd !== 0) begin errs++; $display("FAIL rst_mid_norsp: got %0d responses want 0", n_rd); end
        mon_clear();
        mdl_lat = 3; mdl_rdata = 8'hC3; exp_addr = 24'h000500;
        req1_we = 1'b0; req1_addr = 24'h000500; req1_valid = 1'b1;
        run(1, 100);
        vecs++; if (n_rsp[1] !== 1 || rd_log[0] !== 8'hC3 || err_log[0] !== 1'b0) begin
            errs++; $display("FAIL rst_mid_after: got n %0d rd %h err %b want 1 c3 0", n_rsp[1], rd_log[0], err_log[0]); end
    endtask

    task automatic test_back_to_back();
        mon_clear();
        mdl_lat = 2; mdl_rdata = 8'h96; exp_addr = 24'h000777; want0 = 3;
        req0_we = 1'b0; req0_addr = 24'h000777; req0_valid = 1'b1;
        run(3, 200);
        vecs++; if (n_rdy[0] !== 3 || n_rsp[0] !== 3) begin errs++; $display("FAIL b2b_counts: ready %0d rsp %0d want 3 3", n_rdy[0], n_rsp[0]); end
        vecs++; if (bad_order !== 0 || rdy_while_out !== 0) begin errs++; $display("FAIL b2b_order: got %0d/%0d want 0/0", bad_order, rdy_while_out); end
        for (int i = 0; i < 3; i++) begin
            vecs++; if (rd_log[i] !== 8'h96) begin errs++; $display("FAIL b2b_data%0d: got %h want 96", i, rd_log[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_tie();
        test_stray_done();
        test_timeout();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
